// File: rtl/gray2rgb_serializer.sv
// gray2rgb_serializer
//   Re-expands a stream of gray pixels into R,G,B byte beats (R=G=B=gray)
//   for the byte transmitter. It tracks the pixel position within a frame,
//   flags the last byte of each frame and pulses once the frame is out.
//
// Ports
//   clk_i         clock, rising edge
//   rst_i         synchronous active-high reset
//   gray_i        gray pixel from upstream
//   valid_i       upstream pixel valid
//   ready_o       block can take a pixel this cycle
//   data_o        output byte (R, G or B value)
//   valid_o       data_o valid
//   ready_i       downstream accepts byte
//   channel_o     current beat: 0=R, 1=G, 2=B
//   last_o        B beat of the final pixel of a frame
//   frame_done_o  one-cycle pulse after the final B beat handshakes
//
// state  | meaning
// IDLE   | no pixel held, waiting for upstream
// SEND_R | presenting R beat of pixel_q
// SEND_G | presenting G beat of pixel_q
// SEND_B | presenting B beat; may take the next pixel in the same cycle

module gray2rgb_serializer #(
    parameter int WIDTH_P        = 8,
    parameter int FRAME_PIXELS_P = 307200,
    parameter int CNT_WIDTH_P    = $clog2(FRAME_PIXELS_P) + 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [WIDTH_P-1:0] gray_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic [WIDTH_P-1:0] data_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [1:0]         channel_o,
    output logic               last_o,
    output logic               frame_done_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_R = 2'd1,
        SEND_G = 2'd2,
        SEND_B = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH_P-1:0] LAST_CNT_C = CNT_WIDTH_P'(FRAME_PIXELS_P - 1);
    localparam logic [CNT_WIDTH_P-1:0] ONE_C      = CNT_WIDTH_P'(1);

    state_t                 r_state;
    logic [WIDTH_P-1:0]     r_pixel;
    logic [CNT_WIDTH_P-1:0] r_pix_cnt;
    logic                   r_frame_done;

    logic w_in_fire;
    logic w_out_fire;
    logic w_last;

    // ready_i -> ready_o is the only combinational path: on the B beat the
    // next pixel is taken in the same cycle the B byte leaves, keeping
    // valid_o continuous at one pixel per three cycles.
    assign ready_o    = !rst_i && ((r_state == IDLE) || ((r_state == SEND_B) && ready_i));
    assign w_in_fire  = valid_i && ready_o;
    assign w_out_fire = valid_o && ready_i;
    assign w_last     = (r_state == SEND_B) && (r_pix_cnt == LAST_CNT_C);

    // Outputs decode the state/pixel flops only, so they stay stable under stall.
    assign valid_o      = (r_state != IDLE);
    assign data_o       = r_pixel;
    assign last_o       = w_last;
    assign frame_done_o = r_frame_done;

    always_comb begin
        channel_o = 2'd0;
        case (r_state)
            SEND_G:  channel_o = 2'd1;
            SEND_B:  channel_o = 2'd2;
            default: channel_o = 2'd0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_pixel      <= '0;
            r_pix_cnt    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_out_fire && w_last;
            case (r_state)
                IDLE: begin
                    if (w_in_fire) begin
                        r_pixel <= gray_i;
                        r_state <= SEND_R;
                    end
                end
                SEND_R: begin
                    if (w_out_fire) r_state <= SEND_G;
                end
                SEND_G: begin
                    if (w_out_fire) r_state <= SEND_B;
                end
                SEND_B: begin
                    if (w_out_fire) begin
                        r_pix_cnt <= w_last ? '0 : r_pix_cnt + ONE_C;
                        if (w_in_fire) begin
                            r_pixel <= gray_i;
                            r_state <= SEND_R;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/gray2rgb_serializer.md
Name: gray2rgb_serializer

Overview:
- Output-side counterpart of the RGB-to-gray front end. It accepts one gray pixel per valid/ready handshake and re-expands it to R, G, B byte beats with R=G=B=gray.
- It emits those beats as a byte stream with valid/ready toward the byte transmitter (UART TX path), so processed frames return in the same 3-bytes-per-pixel format the front end consumes.
- It tracks pixel position within a frame and flags the final byte of each frame.

Parameters:
- WIDTH_P, 8, pixel/byte width in bits.
- FRAME_PIXELS_P, 307200, pixels per frame (640x480); must be >= 1.
- CNT_WIDTH_P, $clog2(FRAME_PIXELS_P)+1, pixel counter width (derived; do not override).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- gray_i  in  WIDTH_P  gray pixel from upstream.
- valid_i  in  1  upstream pixel valid.
- ready_o  out  1  block can accept a pixel this cycle.
- data_o  out  WIDTH_P  output byte (R, G or B channel value).
- valid_o  out  1  data_o valid.
- ready_i  in  1  downstream accepts byte.
- channel_o  out  2  current beat: 0=R, 1=G, 2=B (3 never driven).
- last_o  out  1  high with the B beat of the final pixel of a frame.
- frame_done_o  out  1  one-cycle pulse after the final B beat handshakes.

Behaviour:
- Handshake definitions: in_fire = valid_i & ready_o; out_fire = valid_o & ready_i.
- FSM states: IDLE, SEND_R, SEND_G, SEND_B.
  - IDLE: in_fire -> SEND_R; capture gray_i into pixel_q.
  - SEND_R: out_fire -> SEND_G; else hold.
  - SEND_G: out_fire -> SEND_B; else hold.
  - SEND_B: out_fire & in_fire -> SEND_R with new pixel_q (back-to-back). out_fire & !in_fire -> IDLE. No out_fire -> hold.
- ready_o combinational: (state==IDLE) | (state==SEND_B & ready_i); forced 0 while rst_i=1.
- Outputs are registered state decodes:
  - valid_o = (state != IDLE).
  - data_o = pixel_q.
  - channel_o = 0/1/2 for SEND_R/G/B; 0 in IDLE.
- Latency: pixel accepted at edge N; R beat is valid in the cycle after edge N.
- Throughput: with ready_i held high and valid_i continuous, one pixel per 3 cycles and valid_o never drops.
- Stall: while valid_o & !ready_i, data_o, channel_o and last_o hold stable. pixel_q changes only on in_fire.
- Pixel counter pix_cnt:
  - Increments on out_fire in SEND_B.
  - Wraps from FRAME_PIXELS_P-1 to 0 on that fire.
  - Never increments on R or G beats.
- last_o = (state==SEND_B) & (pix_cnt == FRAME_PIXELS_P-1).
- frame_done_o = registered pulse, high exactly one cycle after the out_fire where last_o=1.
- FRAME_PIXELS_P=1: last_o is high on every B beat.
- Arithmetic: no scaling or rounding; data_o is bit-exact gray_i on all three beats.
- Reset:
  - State IDLE, pixel_q=0, pix_cnt=0.
  - Outputs: valid_o=0, data_o=0, channel_o=0, last_o=0, frame_done_o=0.
  - Reset mid-pixel discards the partial R/G/B sequence and restarts the frame count; the first pixel after reset is pixel 0.
- No combinational path from valid_i to valid_o. The only combinational path is ready_i -> ready_o.

Test Plan:
- Single pixel, FRAME_PIXELS_P=4, ready_i=1, gray_i=0xA5 for one cycle:
  - Three beats data_o=0xA5 with channel_o=0,1,2 on consecutive cycles.
  - valid_o low afterwards; last_o=0 (pixel 0 of 4).
- Back-to-back, ready_i=1, pixels 0x10, 0x20, 0x30, 0x40 offered continuously (FRAME_PIXELS_P=4):
  - 12 consecutive beats 10,10,10,20,20,20,30,30,30,40,40,40 with no valid_o gap.
  - ready_o high only in IDLE and on each B beat.
  - last_o only on beat 12; frame_done_o one cycle later.
- Backpressure, pixel 0x7E, ready_i low for 5 cycles during the G beat:
  - data_o=0x7E and channel_o=1 stable throughout the stall.
  - ready_o=0; no beat duplicated or dropped.
- Frame wrap, FRAME_PIXELS_P=4, send 9 pixels:
  - last_o on B beats of pixels 3 and 7 only.
  - Two frame_done_o pulses; pix_cnt=1 at end.
- Reset mid-operation: assert rst_i during the G beat of pixel 2, then send one pixel 0x55:
  - Outputs at reset values the cycle after rst_i.
  - 0x55 emitted as a fresh R,G,B sequence counted as pixel 0 (last_o=0 with FRAME_PIXELS_P=4).
- Random valid_i/ready_i toggling, 1000 pixels, FRAME_PIXELS_P=7:
  - Scoreboard output equals each input tripled, in order.
  - last_o every 21st beat; valid_o/data_o never change during a stall.
